// File: rtl/instr_fetch_unit_if.sv
// Byte-wide instruction memory bus used by instr_fetch_unit.
// The fetch unit is the master; the instruction memory is the slave.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [7:0]  imem_data;
    logic        imem_err;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data,
        input  imem_err
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data,
        output imem_err
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Y86-64 instruction fetch: pulls one instruction byte per imem_ack and decodes icode/ifun/regs/valC/valP.
// Optional feature macro FETCH_TIMEOUT_EN aborts a byte with stat ADR after TIMEOUT_CYC unacknowledged cycles.
module instr_fetch_unit #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fetch_req_i,
    input  logic [63:0]               pc_i,
    output logic                      fetch_ready_o,
    instr_fetch_unit_if.master        imem,
    output logic [3:0]                icode_o,
    output logic [3:0]                ifun_o,
    output logic [3:0]                ra_o,
    output logic [3:0]                rb_o,
    output logic [63:0]               valc_o,
    output logic [63:0]               valp_o,
    output logic                      instr_valid_o,
    input  logic                      instr_taken_i,
    output logic [1:0]                stat_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BYTE0 = 3'd1,
        S_REGS  = 3'd2,
        S_CONST = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        LEN1  = 2'd0,
        LEN2  = 2'd1,
        LEN9  = 2'd2,
        LEN10 = 2'd3
    } len_e;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_INS = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_HLT = 2'd3;

    // Undefined icodes (C-F) fall into LEN1 so they finish after the opcode byte.
    function automatic len_e len_of(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       len_of = LEN1;
            4'h2, 4'h6, 4'hA, 4'hB: len_of = LEN2;
            4'h7, 4'h8:             len_of = LEN9;
            4'h3, 4'h4, 4'h5:       len_of = LEN10;
            default:                len_of = LEN1;
        endcase
    endfunction

    function automatic logic [3:0] len_bytes(input len_e l);
        case (l)
            LEN1:    len_bytes = 4'd1;
            LEN2:    len_bytes = 4'd2;
            LEN9:    len_bytes = 4'd9;
            LEN10:   len_bytes = 4'd10;
            default: len_bytes = 4'd1;
        endcase
    endfunction

    state_e      state_q, state_d;
    len_e        len_q;
    len_e        byte0_len_s;
    logic [63:0] pc_q;
    logic [63:0] addr_q;
    logic [2:0]  cnt_q;
    logic [3:0]  icode_q, ifun_q, ra_q, rb_q;
    logic [63:0] valc_q, valp_q;
    logic [1:0]  stat_q;
    logic        busy_s;
    logic        byte_ack_s;
    logic        timeout_s;

    assign busy_s      = (state_q == S_BYTE0) || (state_q == S_REGS) || (state_q == S_CONST);
    assign byte_ack_s  = busy_s && imem.imem_ack;
    assign byte0_len_s = len_of(imem.imem_data[7:4]);

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q;

    assign timeout_s = busy_s && !imem.imem_ack && (tmo_q == TW'(TIMEOUT_CYC - 1));

    // Count consecutive unacknowledged request cycles of the current byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else if (!busy_s || imem.imem_ack || timeout_s) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TW'(1);
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: an error ack or a timeout ends the instruction at once
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (fetch_req_i) begin
                    state_d = S_BYTE0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BYTE0: begin
                if (byte_ack_s) begin
                    if (imem.imem_err || (byte0_len_s == LEN1)) begin
                        state_d = S_DONE;
                    end else if (byte0_len_s == LEN9) begin
                        state_d = S_CONST;
                    end else begin
                        state_d = S_REGS;
                    end
                end else if (timeout_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_BYTE0;
                end
            end
            S_REGS: begin
                if (byte_ack_s) begin
                    if (imem.imem_err || (len_q == LEN2)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CONST;
                    end
                end else if (timeout_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_REGS;
                end
            end
            S_CONST: begin
                if (byte_ack_s) begin
                    if (imem.imem_err || (cnt_q == 3'd7)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CONST;
                    end
                end else if (timeout_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CONST;
                end
            end
            S_DONE: begin
                if (instr_taken_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the registered state
    always_comb begin
        fetch_ready_o = 1'b0;
        imem.imem_req = 1'b0;
        instr_valid_o = 1'b0;
        case (state_q)
            S_IDLE:                   fetch_ready_o = 1'b1;
            S_BYTE0, S_REGS, S_CONST: imem.imem_req = 1'b1;
            S_DONE:                   instr_valid_o = 1'b1;
            default: begin
                fetch_ready_o = 1'b0;
                imem.imem_req = 1'b0;
                instr_valid_o = 1'b0;
            end
        endcase
    end

    // Datapath: fields are cleared at accept so anything not reached before an abort reads 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= 64'd0;
            addr_q  <= 64'd0;
            cnt_q   <= 3'd0;
            len_q   <= LEN1;
            icode_q <= 4'h0;
            ifun_q  <= 4'h0;
            ra_q    <= 4'hF;
            rb_q    <= 4'hF;
            valc_q  <= 64'd0;
            valp_q  <= 64'd0;
            stat_q  <= STAT_AOK;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fetch_req_i) begin
                        pc_q    <= pc_i;
                        addr_q  <= pc_i;
                        cnt_q   <= 3'd0;
                        len_q   <= LEN1;
                        icode_q <= 4'h0;
                        ifun_q  <= 4'h0;
                        ra_q    <= 4'h0;
                        rb_q    <= 4'h0;
                        valc_q  <= 64'd0;
                        valp_q  <= 64'd0;
                        stat_q  <= STAT_AOK;
                    end
                end
                S_BYTE0, S_REGS, S_CONST: begin
                    if (byte_ack_s) begin
                        addr_q <= addr_q + 64'd1;
                        if (imem.imem_err) begin
                            stat_q <= STAT_ADR;
                        end else if (state_q == S_BYTE0) begin
                            icode_q <= imem.imem_data[7:4];
                            ifun_q  <= imem.imem_data[3:0];
                            len_q   <= byte0_len_s;
                            valp_q  <= pc_q + {60'd0, len_bytes(byte0_len_s)};
                            if ((byte0_len_s == LEN1) || (byte0_len_s == LEN9)) begin
                                ra_q <= 4'hF;
                                rb_q <= 4'hF;
                            end
                            if (imem.imem_data[7:4] >= 4'hC) begin
                                stat_q <= STAT_INS;
                            end else if (imem.imem_data[7:4] == 4'h0) begin
                                stat_q <= STAT_HLT;
                            end else begin
                                stat_q <= STAT_AOK;
                            end
                        end else if (state_q == S_REGS) begin
                            ra_q <= imem.imem_data[7:4];
                            rb_q <= imem.imem_data[3:0];
                        end else begin
                            valc_q[{cnt_q, 3'b000} +: 8] <= imem.imem_data;
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end else if (timeout_s) begin
                        stat_q <= STAT_ADR;
                    end
                end
                default: begin
                    cnt_q <= cnt_q;
                end
            endcase
        end
    end

    assign imem.imem_addr = addr_q;
    assign icode_o        = icode_q;
    assign ifun_o         = ifun_q;
    assign ra_o           = ra_q;
    assign rb_o           = rb_q;
    assign valc_o         = valc_q;
    assign valp_o         = valp_q;
    assign stat_o         = stat_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a byte-level Y86-64 fetch model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [63:0] pc_in;
    logic        fetch_ready;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic        instr_valid;
    logic        instr_taken;
    logic [1:0]  stat;

    always #5 clk = ~clk;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(.TIMEOUT_CYC(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_req_i  (fetch_req),
        .pc_i         (pc_in),
        .fetch_ready_o(fetch_ready),
        .imem         (bus.master),
        .icode_o      (icode),
        .ifun_o       (ifun),
        .ra_o         (ra),
        .rb_o         (rb),
        .valc_o       (valc),
        .valp_o       (valp),
        .instr_valid_o(instr_valid),
        .instr_taken_i(instr_taken),
        .stat_o       (stat)
    );

    // Memory model: the instruction bytes live at base_pc .. base_pc+15 (wrapping)
    logic [7:0]  ibytes [0:15];
    logic [63:0] base_pc;
    int          err_idx;
    logic        ack_en;
    logic        ack_force;
    logic [63:0] off_s;

    assign off_s         = bus.imem_addr - base_pc;
    assign bus.imem_ack  = ack_force | (bus.imem_req & ack_en);
    assign bus.imem_data = (off_s < 64'd16) ? ibytes[off_s[3:0]] : 8'h00;
    assign bus.imem_err  = bus.imem_ack && (off_s == 64'(err_idx));

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Handshake monitor: counts byte transfers and checks the address sequence
    int          ack_total = 0;
    int          addr_bad  = 0;
    int          ack_snap;
    logic [63:0] cur_pc;

    always @(posedge clk) begin
        if (bus.imem_req && bus.imem_ack) begin
            if (bus.imem_addr !== cur_pc + 64'(ack_total - ack_snap)) addr_bad++;
            ack_total++;
        end
    end

    // Expected results
    logic [3:0]  exp_icode, exp_ifun, exp_ra, exp_rb;
    logic [63:0] exp_valc, exp_valp;
    logic [1:0]  exp_stat;
    int          exp_nb;

    function automatic int ilen(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       return 1;
            4'h2, 4'h6, 4'hA, 4'hB: return 2;
            4'h7, 4'h8:             return 9;
            4'h3, 4'h4, 4'h5:       return 10;
            default:                return 1;
        endcase
    endfunction

    task automatic ref_model(input logic [63:0] pc, input int err);
        logic [3:0] ic;
        int         len, coff;
        bit         hreg;
        ic   = ibytes[0][7:4];
        len  = ilen(ic);
        hreg = (len == 2) || (len == 10);
        coff = hreg ? 2 : 1;
        exp_nb = (err < len) ? err + 1 : len;
        if (err < len)         exp_stat = 2'd2;
        else if (ic >= 4'd12)  exp_stat = 2'd1;
        else if (ic == 4'd0)   exp_stat = 2'd3;
        else                   exp_stat = 2'd0;
        exp_icode = (err == 0) ? 4'h0 : ic;
        exp_ifun  = (err == 0) ? 4'h0 : ibytes[0][3:0];
        exp_valp  = (err == 0) ? 64'd0 : pc + 64'(len);
        if (err == 0) begin
            exp_ra = 4'h0; exp_rb = 4'h0;
        end else if (!hreg) begin
            exp_ra = 4'hF; exp_rb = 4'hF;
        end else if (err == 1) begin
            exp_ra = 4'h0; exp_rb = 4'h0;
        end else begin
            exp_ra = ibytes[1][7:4]; exp_rb = ibytes[1][3:0];
        end
        exp_valc = 64'd0;
        if (len >= 9) begin
            for (int k = 0; k < 8; k++) begin
                if (coff + k < err) exp_valc = exp_valc | (64'(ibytes[coff + k]) << (8 * k));
            end
        end
    endtask

    task automatic set_bytes(input logic [79:0] b);
        for (int i = 0; i < 16; i++) ibytes[i] = (i < 10) ? b[79 - 8*i -: 8] : 8'h00;
    endtask

    task automatic run_instr(input logic [63:0] pc, input int err, input bit zero_wait);
        int cyc;
        int bad0;
        base_pc  = pc;
        cur_pc   = pc;
        err_idx  = err;
        ack_snap = ack_total;
        bad0     = addr_bad;
        ref_model(pc, err);
        @(negedge clk);
        check_val("ready_idle", 64'(fetch_ready), 64'd1);
        fetch_req = 1'b1;
        pc_in     = pc;
        ack_en    = zero_wait ? 1'b1 : 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        pc_in     = 64'($urandom);
        cyc       = 1;
        @(negedge clk);
        while (!instr_valid && cyc < 300) begin
            if (!zero_wait) ack_en = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check_val("valid_seen", 64'(instr_valid), 64'd1);
        if (zero_wait) check_val("latency", 64'(cyc), 64'(exp_nb + 1));
        check_val("icode", 64'(icode), 64'(exp_icode));
        check_val("ifun", 64'(ifun), 64'(exp_ifun));
        check_val("rA", 64'(ra), 64'(exp_ra));
        check_val("rB", 64'(rb), 64'(exp_rb));
        check_val("valC", valc, exp_valc);
        check_val("valP", valp, exp_valp);
        check_val("stat", 64'(stat), 64'(exp_stat));
        check_val("nbytes", 64'(ack_total - ack_snap), 64'(exp_nb));
        check_val("addr_seq", 64'(addr_bad - bad0), 64'd0);
        ack_en = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            check_val("valid_hold", 64'(instr_valid), 64'd1);
            check_val("ready_done", 64'(fetch_ready), 64'd0);
        end
        @(negedge clk);
        instr_taken = 1'b1;
        fetch_req   = 1'b1;
        @(posedge clk);
        #1;
        instr_taken = 1'b0;
        fetch_req   = 1'b0;
        @(negedge clk);
        check_val("valid_drop", 64'(instr_valid), 64'd0);
        check_val("no_accept_on_take", 64'(fetch_ready), 64'd1);
    endtask

    initial begin
        int cyc;
        rst_n       = 1'b0;
        fetch_req   = 1'b0;
        pc_in       = 64'd0;
        instr_taken = 1'b0;
        ack_en      = 1'b0;
        ack_force   = 1'b0;
        err_idx     = 99;
        base_pc     = 64'd0;
        cur_pc      = 64'd0;
        ack_snap    = 0;
        set_bytes(80'h0);
        repeat (3) @(negedge clk);
        check_val("rst_ready", 64'(fetch_ready), 64'd1);
        check_val("rst_valid", 64'(instr_valid), 64'd0);
        check_val("rst_req", 64'(bus.imem_req), 64'd0);
        check_val("rst_addr", bus.imem_addr, 64'd0);
        check_val("rst_rA", 64'(ra), 64'hF);
        check_val("rst_rB", 64'(rb), 64'hF);
        check_val("rst_stat", 64'(stat), 64'd0);
        check_val("rst_valC", valc, 64'd0);
        check_val("rst_valP", valp, 64'd0);
        rst_n = 1'b1;

        set_bytes(80'h30F3_0800_0000_0000_0000);
        run_instr(64'h100, 99, 1'b1);
        set_bytes(80'h7040_0000_0000_0000_0000);
        run_instr(64'h20, 99, 1'b1);
        set_bytes(80'hE0AA_BBCC_0000_0000_0000);
        run_instr(64'h300, 99, 1'b1);
        set_bytes(80'h4012_1122_3344_5566_7788);
        run_instr(64'h400, 2, 1'b1);
        set_bytes(80'h1000_0000_0000_0000_0000);
        run_instr(64'hFFFF_FFFF_FFFF_FFFF, 99, 1'b1);
        set_bytes(80'h30F3_0102_0304_0506_0708);
        run_instr(64'hFFFF_FFFF_FFFF_FFFC, 99, 1'b1);
        set_bytes(80'h0000_0000_0000_0000_0000);
        run_instr(64'h500, 99, 1'b1);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 16; i++) ibytes[i] = 8'($urandom);
            run_instr(($urandom_range(0, 7) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15)))
                                                  : {32'($urandom), 32'($urandom)},
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : 99,
                      1'($urandom_range(0, 1)));
        end

        // Reset in the middle of the constant bytes
        set_bytes(80'h30F3_0102_0304_0506_0708);
        base_pc  = 64'h600;
        cur_pc   = 64'h600;
        err_idx  = 99;
        ack_snap = ack_total;
        @(negedge clk);
        fetch_req = 1'b1;
        pc_in     = 64'h600;
        ack_en    = 1'b1;
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        cyc = 0;
        while ((ack_total - ack_snap) < 4 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        ack_en = 1'b0;
        check_val("mid_const_reached", 64'(ack_total - ack_snap), 64'd4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_ready", 64'(fetch_ready), 64'd1);
        check_val("mid_rst_req", 64'(bus.imem_req), 64'd0);
        check_val("mid_rst_rA", 64'(ra), 64'hF);
        ack_force = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_val("post_rst_valid", 64'(instr_valid), 64'd0);
        end
        check_val("post_rst_ready", 64'(fetch_ready), 64'd1);
        ack_force = 1'b0;

        // Acknowledge withheld
        set_bytes(80'h30F3_0102_0304_0506_0708);
        base_pc = 64'h700;
        cur_pc  = 64'h700;
        @(negedge clk);
        fetch_req = 1'b1;
        pc_in     = 64'h700;
        ack_en    = 1'b0;
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        cyc = 1;
        @(negedge clk);
        while (!instr_valid && cyc < 101) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
`ifdef FETCH_TIMEOUT_EN
        check_val("tmo_valid", 64'(instr_valid), 64'd1);
        check_val("tmo_cycles", 64'(cyc), 64'd17);
        check_val("tmo_stat", 64'(stat), 64'd2);
        instr_taken = 1'b1;
        @(posedge clk);
        #1;
        instr_taken = 1'b0;
`else
        check_val("no_tmo_valid", 64'(instr_valid), 64'd0);
        check_val("no_tmo_req", 64'(bus.imem_req), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif
        @(negedge clk);
        check_val("final_ready", 64'(fetch_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: cycles to wait for imem_ack before aborting; used only with FETCH_TIMEOUT_EN.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 fetch_req  input  1  request to fetch one instruction at pc.
REQ-005 pc  input  64  byte address of the instruction, sampled at fetch accept.
REQ-006 fetch_ready  output  1  high only in IDLE; fetch accepted when fetch_req && fetch_ready.
REQ-007 imem_req  output  1  byte read request to instruction memory.
REQ-008 imem_addr  output  64  byte address; stable while imem_req high and no ack.
REQ-009 imem_ack  input  1  imem_data/imem_err valid this cycle; completes the byte.
REQ-010 imem_data  input  8  returned instruction byte.
REQ-011 imem_err  input  1  address fault, qualified by imem_ack.
REQ-012 icode, ifun, rA, rB  output  4 each  decoded Y86-64 fields.
REQ-013 valC  output  64  little-endian constant; 0 when the instruction has none.
REQ-014 valP  output  64  pc + instruction length.
REQ-015 instr_valid  output  1  outputs valid; held until instr_taken.
REQ-016 instr_taken  input  1  decode consumes the instruction when instr_valid && instr_taken.
REQ-017 stat  output  2  0 AOK, 1 INS (bad icode), 2 ADR (imem_err or timeout), 3 HLT.

Function
REQ-018 FSM states IDLE, BYTE0, REGS, CONST, DONE; one byte fetched per imem_ack.
REQ-019 IDLE -> BYTE0 on accept; imem_addr = pc, imem_req asserted the next cycle.
REQ-020 BYTE0 on ack: icode = data[7:4], ifun = data[3:0]; lengths: 0,1,9 -> 1; 2,6,A,B -> 2; 7,8 -> 9; 3,4,5 -> 10; C-F -> stat INS, length 1.
REQ-021 Length 1 -> DONE; length 2 or 10 -> REGS; length 9 -> CONST.
REQ-022 REGS on ack: rA = data[7:4], rB = data[3:0]; length 2 -> DONE, else CONST.
REQ-023 CONST collects 8 bytes; byte k lands in valC[8k+7:8k]; after 8th ack -> DONE.
REQ-024 imem_addr increments by 1 after every ack; imem_req may stay high across consecutive bytes; it is low in IDLE and DONE.
REQ-025 rA/rB = 0xF when the instruction has no register byte.
REQ-026 valP = pc + length, 64-bit wrap-around (pc = 0xFFFF_FFFF_FFFF_FFFF, nop -> valP = 0); byte addresses also wrap.
REQ-027 icode 0 -> stat HLT; fetch still completes normally.
REQ-028 imem_err with ack in any byte -> stat ADR, stop fetching, go to DONE immediately; fields already captured are kept, the rest are 0.
REQ-029 DONE: instr_valid = 1; on instr_taken -> IDLE, instr_valid low the next cycle.
REQ-030 In IDLE, fetch_ready = 1; a fetch_req in the same cycle as instr_taken is not accepted (fetch_ready is low in DONE).
REQ-031 Latency, zero-wait memory: instr_valid asserts N+1 cycles after accept, N = bytes fetched.
REQ-032 imem_ack outside BYTE0/REGS/CONST is ignored.

Reset
REQ-033 reset low: state IDLE immediately; all outputs 0 except fetch_ready = 1, rA = rB = 0xF.
REQ-034 Reset mid-fetch abandons the instruction; a pending imem_ack after release is ignored.

Configuration
REQ-035 With FETCH_TIMEOUT_EN defined: a counter resets on each ack or new byte request; after TIMEOUT_CYC cycles with imem_req high and no ack -> stat ADR, go to DONE.
REQ-036 Without FETCH_TIMEOUT_EN: the unit waits for imem_ack indefinitely; no counter is synthesized.

Verification
REQ-037 pc = 0x100, bytes 30 F3 08 00 00 00 00 00 00 00, zero-wait memory -> icode 3, rA F, rB 3, valC 8, valP 0x10A, stat 0, instr_valid 11 cycles after accept.
REQ-038 pc = 0x20, bytes 70 40 00 00 00 00 00 00 00 -> icode 7, ifun 0, rA = rB = F, valC 0x40, valP 0x29.
REQ-039 Byte 0 = 0xE0 -> stat INS, valP = pc + 1, only one imem request issued.
REQ-040 imem_err on the 3rd byte of rmmovq -> stat ADR, instr_valid next cycle, rA/rB captured, valC = 0.
REQ-041 Reset pulsed low during CONST, with instr_taken held low after release -> IDLE, fetch_ready = 1, no instr_valid.
REQ-042 FETCH_TIMEOUT_EN defined, TIMEOUT_CYC = 16, ack withheld -> stat ADR, instr_valid after 16 waiting cycles; with the macro undefined, no instr_valid after 100 cycles.
